// File: rtl/updown_sequencer.sv
// ============================================================================
// Module   : updown_sequencer
// Brief    : Tick divider and load/up/hold/down/hold controller for an
//            external up/down counter datapath. Optional macro: CYCLE_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_sequencer #(
    parameter int CNT_W       = 18,
    parameter int DIV_W       = 26,
    parameter int DIV_FAST    = 5_000_000,
    parameter int DIV_SLOW    = 25_000_000,
    parameter int DWELL_TICKS = 4,
    parameter int MAX_CYCLES  = 3
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             start,
    input  logic             stop,
    input  logic             fast,
    input  logic [CNT_W-1:0] lo_val,
    input  logic [CNT_W-1:0] hi_val,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [CNT_W-1:0] load_val,
    output logic [2:0]       state,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_UP      = 3'd2;
    localparam logic [2:0] c_ST_HOLD_HI = 3'd3;
    localparam logic [2:0] c_ST_DOWN    = 3'd4;
    localparam logic [2:0] c_ST_HOLD_LO = 3'd5;

    localparam logic [DIV_W-1:0] c_DIV_FAST = DIV_W'(DIV_FAST);
    localparam logic [DIV_W-1:0] c_DIV_SLOW = DIV_W'(DIV_SLOW);
    localparam int               c_DWW      = (DWELL_TICKS < 2) ? 1 : $clog2(DWELL_TICKS + 1);
    localparam logic [c_DWW-1:0] c_DWELL    = c_DWW'(DWELL_TICKS);

    // Tick spacing of at least two cycles is what keeps the counter from overshooting.
    generate
        if (DIV_FAST < 2 || DIV_SLOW < 2 || MAX_CYCLES < 1) begin : g_bad_params
            $error("updown_sequencer: divider limits must be >= 2 and MAX_CYCLES >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_limit;
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_lo;
    logic [CNT_W-1:0] r_hi;
    logic [c_DWW-1:0] r_dwell;
    logic             w_dwell_done;
    logic             w_in_hold;
    logic             w_last_cycle;

    assign w_limit      = fast ? c_DIV_FAST : c_DIV_SLOW;
    assign tick         = (r_div_cnt == w_limit);
    assign w_dwell_done = (r_dwell == c_DWELL);
    assign w_in_hold    = (r_state == c_ST_HOLD_HI) || (r_state == c_ST_HOLD_LO);
    assign state        = r_state;

    // A count beyond the limit (rate switched mid-count) also wraps, without a tick.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt >= w_limit) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_lo    <= '0;
            r_hi    <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_ST_IDLE && w_next_state == c_ST_LOAD) begin
                r_lo <= lo_val;
                r_hi <= hi_val;
            end
            if (!w_in_hold) begin
                r_dwell <= '0;
            end else if (tick && !w_dwell_done) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

`ifdef CYCLE_LIMIT_EN
    localparam int               c_CYW  = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [c_CYW-1:0] c_LAST = c_CYW'(MAX_CYCLES - 1);

    logic [c_CYW-1:0] r_cycles;

    assign w_last_cycle = (r_cycles == c_LAST);
    assign done         = (r_state == c_ST_HOLD_LO) && w_dwell_done && w_last_cycle && !stop;

    always_ff @(posedge CLOCK_50) begin
        if (RESET || stop) begin
            r_cycles <= '0;
        end else if (r_state == c_ST_HOLD_LO && w_dwell_done) begin
            r_cycles <= w_last_cycle ? '0 : r_cycles + 1'b1;
        end
    end
`else
    assign w_last_cycle = 1'b0;
    assign done         = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !stop && (lo_val < hi_val)) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD:    w_next_state = c_ST_UP;
            c_ST_UP: begin
                if (cnt_val >= r_hi) begin
                    w_next_state = c_ST_HOLD_HI;
                end
            end
            c_ST_HOLD_HI: begin
                if (w_dwell_done) begin
                    w_next_state = c_ST_DOWN;
                end
            end
            c_ST_DOWN: begin
                if (cnt_val <= r_lo) begin
                    w_next_state = c_ST_HOLD_LO;
                end
            end
            c_ST_HOLD_LO: begin
                if (w_dwell_done) begin
                    w_next_state = w_last_cycle ? c_ST_IDLE : c_ST_UP;
                end
            end
            default:      w_next_state = c_ST_IDLE;
        endcase
        if (stop && r_state != c_ST_IDLE) begin
            w_next_state = c_ST_IDLE;
        end
    end

    // Direction stays at its last value through each hold state.
    always_comb begin
        cnt_en   = 1'b0;
        cnt_up   = 1'b0;
        cnt_load = 1'b0;
        load_val = '0;
        busy     = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_LOAD: begin
                cnt_load = 1'b1;
                load_val = r_lo;
            end
            c_ST_UP: begin
                cnt_up = 1'b1;
                cnt_en = tick && (cnt_val < r_hi);
            end
            c_ST_HOLD_HI: cnt_up = 1'b1;
            c_ST_DOWN:    cnt_en = tick && (cnt_val > r_lo);
            default: begin
                cnt_en = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_updown_sequencer.sv
// ============================================================================
// Module   : tb_updown_sequencer
// Brief    : Directed bench with a datapath counter model and expected-value queues.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_sequencer;

    logic        clk = 1'b0;
    logic        RESET, start, stop, fast;
    logic [17:0] lo_val, hi_val;
    logic        cnt_en, cnt_up, cnt_load, busy, tick, done;
    logic [17:0] load_val;
    logic [2:0]  state;
    logic [17:0] dp_cnt = 18'd0;
    logic [17:0] prev_cnt = 18'd0;

    int checks = 0;
    int errors = 0;
    int gap;

    logic [17:0] q_cnt[$];
    logic [17:0] q_load[$];
    logic        q_tick[$];

    always #5 clk = ~clk;

    updown_sequencer #(
        .DIV_FAST(2), .DIV_SLOW(4), .DWELL_TICKS(2), .MAX_CYCLES(2)
    ) dut (
        .CLOCK_50(clk), .RESET(RESET), .start(start), .stop(stop), .fast(fast),
        .lo_val(lo_val), .hi_val(hi_val), .cnt_val(dp_cnt),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load), .load_val(load_val),
        .state(state), .busy(busy), .tick(tick), .done(done)
    );

    // Datapath counter model; RESET does not touch it.
    always @(posedge clk) begin
        if (cnt_load)    dp_cnt <= load_val;
        else if (cnt_en) dp_cnt <= cnt_up ? dp_cnt + 18'd1 : dp_cnt - 18'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every load strobe and every counter change must match the queues.
    always @(negedge clk) begin
        if (cnt_load === 1'b1) begin
            if (q_load.size() == 0) check("load_unexpected", {31'd0, cnt_load}, 32'd0);
            else                    check("load_val", {14'd0, load_val}, {14'd0, q_load.pop_front()});
        end
        if (dp_cnt !== prev_cnt) begin
            if (q_cnt.size() == 0) check("cnt_unexpected", {14'd0, dp_cnt}, {14'd0, prev_cnt});
            else                   check("cnt_seq", {14'd0, dp_cnt}, {14'd0, q_cnt.pop_front()});
            prev_cnt = dp_cnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 200 && state !== s; i++) step();
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic wait_cnt(input logic [17:0] v, input string tag);
        for (int i = 0; i < 200 && dp_cnt !== v; i++) step();
        check(tag, {14'd0, dp_cnt}, {14'd0, v});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; stop = 1'b0; fast = 1'b1;
        lo_val = 18'd0; hi_val = 18'd0;
        step(); step();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_outs", {23'd0, cnt_en, cnt_up, cnt_load, busy, tick, done, 3'd0},  32'd0);
        check("rst_load_val", {14'd0, load_val}, 32'd0);
        RESET = 1'b0;
        step();

        // Invalid bounds are ignored
        lo_val = 18'd5; hi_val = 18'd5; pulse_start();
        check("inv_eq_state", {29'd0, state}, 32'd0);
        check("inv_eq_busy", {31'd0, busy}, 32'd0);
        lo_val = 18'd7; hi_val = 18'd2; pulse_start();
        check("inv_gt_state", {29'd0, state}, 32'd0);
        check("inv_gt_load", {31'd0, cnt_load}, 32'd0);

        // Basic run 3..6
        lo_val = 18'd3; hi_val = 18'd6;
        q_load.push_back(18'd3);
        foreach (q_cnt[i]) ;
        q_cnt = '{18'd3, 18'd4, 18'd5, 18'd6, 18'd5, 18'd4, 18'd3, 18'd4};
        pulse_start();
        check("load_state", {29'd0, state}, 32'd1);
        check("load_strobe", {30'd0, cnt_load, busy}, 32'd3);
        check("load_dir", {31'd0, cnt_up}, 32'd0);
        step();
        check("up_state", {29'd0, state}, 32'd2);
        check("up_dir", {31'd0, cnt_up}, 32'd1);
        wait_cnt(18'd4, "reach_4");
        gap = 0;
        for (int i = 0; i < 20 && dp_cnt !== 18'd5; i++) begin
            step();
            gap++;
        end
        check("tick_gap_fast", gap, 32'd3);
        wait_state(3'd3, "reach_hold_hi");
        check("hold_hi_cnt", {14'd0, dp_cnt}, 32'd6);
        check("hold_hi_ctl", {30'd0, cnt_en, cnt_up}, 32'd1);
        wait_state(3'd4, "reach_down");
        check("down_dir", {31'd0, cnt_up}, 32'd0);
        wait_state(3'd5, "reach_hold_lo");
        check("hold_lo_cnt", {14'd0, dp_cnt}, 32'd3);
        check("hold_lo_dir", {31'd0, cnt_up}, 32'd0);
        wait_state(3'd2, "back_to_up");
        wait_cnt(18'd4, "reach_4_again");
        check("done_low_run", {31'd0, done}, 32'd0);

        // Stop and start together: stop wins
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("stop_state", {29'd0, state}, 32'd0);
        check("stop_ctl", {30'd0, cnt_en, busy}, 32'd0);
        step(); step(); step();
        check("stop_hold_cnt", {14'd0, dp_cnt}, 32'd4);

        // Restart reloads lo; bounds changed mid-run are ignored; reset in DOWN
        q_load.push_back(18'd3);
        q_cnt = '{18'd3, 18'd4, 18'd5, 18'd6};
        pulse_start();
        check("reload_state", {29'd0, state}, 32'd1);
        lo_val = 18'd1; hi_val = 18'd8;
        wait_state(3'd3, "rerun_hold_hi");
        check("old_hi_used", {14'd0, dp_cnt}, 32'd6);
        wait_state(3'd4, "rerun_down");
        RESET = 1'b1;
        step();
        check("midrst_state", {29'd0, state}, 32'd0);
        check("midrst_outs", {26'd0, cnt_en, cnt_up, cnt_load, busy, tick, done}, 32'd0);
        check("midrst_load_val", {14'd0, load_val}, 32'd0);
        RESET = 1'b0;
        step();
        check("midrst_cnt_kept", {14'd0, dp_cnt}, 32'd6);
        q_load.push_back(18'd1);
        q_cnt.push_back(18'd1);
        pulse_start();
        check("newb_state", {29'd0, state}, 32'd1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("newb_stop", {29'd0, state}, 32'd0);

        // Speed change: slow divider, then fast while div_cnt = 3
        fast = 1'b0;
        for (int i = 0; i < 20 && tick !== 1'b1; i++) step();
        check("slow_tick_seen", {31'd0, tick}, 32'd1);
        for (int i = 0; i < 4; i++) q_tick.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("slow_tick_seq", {31'd0, tick}, {31'd0, q_tick.pop_front()});
        end
        fast = 1'b1;
        #1;
        check("switch_no_tick", {31'd0, tick}, 32'd0);
        q_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step();
            check("fast_tick_seq", {31'd0, tick}, {31'd0, q_tick.pop_front()});
        end

`ifdef CYCLE_LIMIT_EN
        lo_val = 18'd0; hi_val = 18'd2;
        q_load.push_back(18'd0);
        q_cnt = '{18'd0, 18'd1, 18'd2, 18'd1, 18'd0, 18'd1, 18'd2, 18'd1, 18'd0};
        pulse_start();
        for (int i = 0; i < 400 && done !== 1'b1; i++) step();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_in_hold_lo", {29'd0, state}, 32'd5);
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("done_idle", {29'd0, state}, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("stays_idle", {29'd0, state}, 32'd0);
`else
        for (int i = 0; i < 5; i++) begin
            step();
            check("done_tied_low", {31'd0, done}, 32'd0);
        end
`endif

        step();
        check("cnt_queue_empty", q_cnt.size(), 32'd0);
        check("load_queue_empty", q_load.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/updown_sequencer.md
Name: updown_sequencer

Overview:
- Controller for the 18-bit up/down binary counter datapath on the DE2-115.
- Generates the visible-rate tick and sequences the counter through a repeating pattern: load low bound, count up to high bound, dwell, count down to low bound, dwell, repeat.
- The counter register lives in the datapath. This block drives its enable, direction and load controls, and reads the counter value back.

Parameters:
- CNT_W, 18: counter / bound width.
- DIV_W, 26: divider width.
- DIV_FAST, 5_000_000: divider limit when fast=1 (~10 Hz). Must be ≥2.
- DIV_SLOW, 25_000_000: divider limit when fast=0 (~2 Hz). Must be ≥2.
- DWELL_TICKS, 4: ticks spent in each hold state.
- MAX_CYCLES, 3: full up/down cycles before auto-stop. Used only with CYCLE_LIMIT_EN.

Ports:
- CLOCK_50  in  1  50 MHz clock.
- RESET  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a sequence.
- stop  in  1  one-cycle pulse; aborts to IDLE.
- fast  in  1  tick rate select (1 = DIV_FAST).
- lo_val  in  CNT_W  lower bound.
- hi_val  in  CNT_W  upper bound.
- cnt_val  in  CNT_W  current counter value fed back from datapath.
- cnt_en  out  1  datapath count enable.
- cnt_up  out  1  datapath direction (1 = up).
- cnt_load  out  1  datapath synchronous load strobe.
- load_val  out  CNT_W  datapath load value.
- state  out  3  FSM state code.
- busy  out  1  high in every state except IDLE.
- tick  out  1  divider tick.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (RESET=1 at clock edge):
  - State IDLE; divider, dwell counter and cycle counter at 0.
  - lo_r and hi_r at 0.
  - All outputs 0.
  - Reset mid-sequence aborts immediately; the datapath value is not touched.
- Divider:
  - limit = fast ? DIV_FAST : DIV_SLOW.
  - div_cnt counts 0..limit; tick = (div_cnt == limit), combinational; div_cnt returns to 0 on the following edge.
  - If div_cnt > limit (fast switched mid-count), div_cnt clears to 0 on the next edge with no tick.
  - Divider runs in all states.
- State codes: IDLE=0, LOAD=1, UP=2, HOLD_HI=3, DOWN=4, HOLD_LO=5.
- IDLE:
  - Outputs 0.
  - start=1 with lo_val < hi_val (unsigned): capture lo_r=lo_val and hi_r=hi_val, go to LOAD.
  - start with lo_val ≥ hi_val is ignored.
- LOAD (one cycle): cnt_load=1, load_val=lo_r. Go to UP.
- UP: cnt_up=1, cnt_en=tick while cnt_val < hi_r. When cnt_val ≥ hi_r: cnt_en=0, go to HOLD_HI, clear dwell counter.
- HOLD_HI: cnt_en=0. Dwell counter increments on each tick; when the count reaches DWELL_TICKS, go to DOWN. DWELL_TICKS=0 gives a one-cycle hold.
- DOWN: cnt_up=0, cnt_en=tick while cnt_val > lo_r. When cnt_val ≤ lo_r: go to HOLD_LO, clear dwell counter.
- HOLD_LO: same dwell rule as HOLD_HI, then go to UP (or IDLE, see Optional Feature).
- Overshoot: cnt_en is qualified by tick, and ticks are ≥2 cycles apart. The controller therefore sees each new cnt_val before the next enable, and the counter never passes a bound.
- cnt_up: holds its last value in the HOLD states; 0 in IDLE and LOAD.
- stop:
  - From any non-IDLE state, go to IDLE on the next edge; outputs drop, the counter value is retained.
  - stop with start in the same cycle: stop wins.
  - start while busy is ignored.
- Bounds: lo_val/hi_val changes while busy have no effect until the next start.
- done: 0 without the macro.

Optional Feature:
- Macro: CYCLE_LIMIT_EN.
- Defined:
  - Cycle counter increments on each HOLD_LO exit.
  - When it reaches MAX_CYCLES, go to IDLE instead of UP, pulse done=1 for one cycle, and clear the cycle counter.
  - stop clears the cycle counter without asserting done.
- Undefined: the sequence repeats until stop or reset; done tied 0; no cycle counter logic.

Test Plan (bench params DIV_FAST=2, DIV_SLOW=4, DWELL_TICKS=2, MAX_CYCLES=2; bench models the datapath counter):
- Basic run: RESET, then lo=3, hi=6, fast=1, start. Expected: LOAD loads 3; counter steps 3→4→5→6 on ticks 3 cycles apart; HOLD_HI for 2 ticks; 6→3; HOLD_LO; back to UP. cnt_val never leaves 3..6.
- Invalid bounds: start with lo=5, hi=5, and again with lo=7, hi=2. Expected: stays IDLE, busy=0, no cnt_load.
- Stop priority: stop and start together mid-UP at cnt_val=4. Expected: IDLE next cycle, cnt_en=0, counter holds 4; a later start reloads lo.
- Speed change: fast 0→1 while div_cnt=3 (limit 4→2). Expected: div_cnt clears with no tick, then ticks resume every 3 cycles.
- Reset mid-run: RESET in DOWN. Expected: state=0, busy=0, all outputs 0 next cycle; bounds changed during the run are not used until the next start.
- CYCLE_LIMIT_EN: lo=0, hi=2. Expected: exactly 2 full up/down cycles, then a single-cycle done=1 and IDLE. Without the macro, done stays 0 for 5 cycles.
